dmem_arbiter: RTL
=================

# dmem_arbiter

Two-way arbiter that shares the single-ported data memory between the pipeline MEM stage and a DMA/loader requester. The CPU has priority. The DMA port steals idle MEM-stage cycles, and after a bounded wait it forces a short burst while the pipeline is stalled. It sits between the EX/MEM pipeline register outputs and the data memory, and drives the pipeline's global stall.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_WAIT, 8, contended cycles a DMA request tolerates before a forced burst (≥1)
- BURST_LEN, 4, maximum DMA accesses per forced burst (≥1)

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  MEM stage access request (MemRead | MemWrite)
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU byte address
- cpu_wdata  in  DATA_W  CPU store data
- cpu_rdata  out  DATA_W  load data to the MEM/WB register
- cpu_stall  out  1  freeze the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers
- dma_req  in  1  DMA access request, held until granted
- dma_we  in  1  1 = write, 0 = read
- dma_addr  in  ADDR_W  DMA address
- dma_wdata  in  DATA_W  DMA write data
- dma_gnt  out  1  DMA access is performed this cycle
- dma_rvalid  out  1  registered read-data strobe
- dma_rdata  out  DATA_W  registered read data
- mem_addr  out  ADDR_W  to data memory
- mem_wdata  out  DATA_W  to data memory
- mem_rd  out  1  memory read enable
- mem_wr  out  1  memory write enable
- mem_rdata  in  DATA_W  combinational read data from memory
- in_burst  out  1  FSM is in FORCE (debug/LED)

## Operation
- **FSM states:** CPU_OWN (reset state) and FORCE.
- **CPU_OWN, cpu_req=1:** CPU is granted.
  - mem_* carry the CPU fields.
  - mem_rd = !cpu_we, mem_wr = cpu_we.
  - dma_gnt = 0, cpu_stall = 0.
- **CPU_OWN, cpu_req=0 and dma_req=1:** idle steal.
  - dma_gnt = 1 and mem_* carry the DMA fields.
  - No stall.
- **Neither requesting:** mem_rd = mem_wr = 0.
  - mem_addr and mem_wdata select the CPU fields.
- **Wait counter (wait_cnt, width clog2(MAX_WAIT)+1):**
  - Increments each CPU_OWN cycle with cpu_req & dma_req.
  - Clears on any dma_gnt, and when dma_req = 0.
  - If a contended cycle occurs with wait_cnt == MAX_WAIT-1, the next state is FORCE and wait_cnt clears.
- **FORCE:**
  - cpu_stall = cpu_req.
  - dma_gnt = dma_req, and mem_* carry the DMA fields when dma_req = 1.
  - burst_cnt (width clog2(BURST_LEN)+1) increments per granted access.
  - Return to CPU_OWN after the grant that makes burst_cnt == BURST_LEN, or on any FORCE cycle with dma_req = 0 (no grant that cycle).
  - burst_cnt clears on exit.
- **cpu_rdata** = mem_rdata (pass-through). It is valid only in cycles where the CPU is granted.
- **DMA reads:** on a granted DMA read, dma_rvalid = 1 and dma_rdata = mem_rdata are registered at the next edge. Otherwise dma_rvalid = 0 and dma_rdata holds its value.
- **Same-cycle events:** the dma_req/cpu_req change in the same cycle as the FORCE exit uses that cycle's values. A burst never overlaps a CPU grant.
- **Reset (any time, including mid-burst):**
  - FSM goes to CPU_OWN; wait_cnt = 0, burst_cnt = 0.
  - dma_rvalid = 0, dma_rdata = 0.
  - Combinational outputs follow their inputs accordingly: cpu_stall = 0, dma_gnt = cpu_req ? 0 : dma_req, in_burst = 0.

## Timing
- Grant decisions are combinational from the current state and requests. Accesses complete in the granted cycle.
- CPU load latency is 0 cycles, unchanged from the unarbitrated pipeline.
- DMA read latency: dma_rvalid one cycle after dma_gnt.
- Worst-case DMA wait under continuous CPU traffic: MAX_WAIT cycles. With defaults, a request at cycle 0 is granted at cycle 8.
- Worst-case CPU stall per burst: BURST_LEN cycles. A new burst needs a fresh MAX_WAIT of contention.
- cpu_stall is combinational. The pipeline must gate every stage register with it.

## Test plan
- **Reset:** hold reset = 0 with both requests high → dma_gnt = 0, cpu_stall = 0, in_burst = 0, dma_rvalid = 0, dma_rdata = 0, and mem_* carry the CPU fields. Release reset → the CPU is served in the first cycle.
- **Idle steal:** cpu_req = 0, DMA read at 0x40 (memory holds 0x1234_5678) → dma_gnt = 1, mem_rd = 1, mem_addr = 0x40 that cycle. The next cycle gives dma_rvalid = 1 and dma_rdata = 0x1234_5678, with no stall.
- **Forced burst:** cpu_req and dma_req held high from cycle 0 →
  - cycles 0–7: CPU served, dma_gnt = 0.
  - cycles 8–11: in_burst = 1, cpu_stall = 1, dma_gnt = 1.
  - cycle 12: CPU served again and in_burst = 0.
- **Early exit:** same setup, but dma_req drops at cycle 10 → cycles 8–9 are granted. In cycle 10 there is no grant, and cpu_stall = 1 is still asserted while in FORCE. Cycle 11 is back in CPU_OWN, and wait_cnt restarts from 0.
- **Write path:** DMA write 0xDEAD_BEEF to 0x80 via steal, then CPU load of 0x80 → cpu_rdata = 0xDEAD_BEEF in the CPU's granted cycle.
- **Reset mid-burst:** assert reset at cycle 9 of the forced-burst scenario → cpu_stall and in_burst fall immediately (asynchronously). After release, contention again takes 8 cycles before the next burst.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles the CPU MEM-stage port, the DMA/loader port and the data-memory port
// that meet at the data-memory arbiter.
//
//   slave  : the arbiter's view (takes requests and mem_rdata, drives grants,
//            stall, DMA read return and the memory command)
//   master : the surrounding system's view (CPU, DMA engine and memory)
//
// Signals:
//   cpu_req/cpu_we/cpu_addr/cpu_wdata  CPU access request and fields
//   cpu_rdata, cpu_stall               load data and global pipeline stall
//   dma_req/dma_we/dma_addr/dma_wdata  DMA access request and fields
//   dma_gnt, dma_rvalid, dma_rdata     DMA grant and registered read return
//   mem_addr/mem_wdata/mem_rd/mem_wr   command to the single-ported memory
//   mem_rdata                          combinational read data from memory
//   in_burst                           forced DMA burst in progress
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt;
    logic              dma_rvalid;
    logic [DATA_W-1:0] dma_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_rdata;

    logic              in_burst;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  mem_rdata,
        output cpu_rdata, cpu_stall,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_addr, mem_wdata, mem_rd, mem_wr,
        output in_burst
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output mem_rdata,
        input  cpu_rdata, cpu_stall,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_addr, mem_wdata, mem_rd, mem_wr,
        input  in_burst
    );
endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-ported data memory between the pipeline MEM stage (CPU)
// and a DMA/loader requester. The CPU has priority; the DMA port uses idle
// MEM-stage cycles. A DMA request that sees MAX_WAIT contended cycles forces
// a burst of up to BURST_LEN DMA accesses while the pipeline is stalled.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-low reset
//   bus    dmem_arbiter_if.slave (CPU, DMA and memory sides)
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_WAIT  = 8,
    parameter int BURST_LEN = 4
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);
    localparam int WAIT_W  = $clog2(MAX_WAIT) + 1;
    localparam int BURST_W = $clog2(BURST_LEN) + 1;

    // Last contended cycle before a forced burst, and last access of a burst.
    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(MAX_WAIT - 1);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST_LEN - 1);

    typedef enum logic {
        CPU_OWN = 1'b0,
        FORCE   = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic [WAIT_W-1:0]  w_wait_nxt;
    logic [BURST_W-1:0] r_burst_cnt;
    logic [BURST_W-1:0] w_burst_nxt;

    logic               r_dma_rvalid;
    logic [DATA_W-1:0]  r_dma_rdata;

    logic               w_cpu_gnt;
    logic               w_dma_gnt;
    logic               w_dma_rd;
    logic [ADDR_W-1:0]  w_mem_addr;
    logic [DATA_W-1:0]  w_mem_wdata;
    logic               w_mem_rd;
    logic               w_mem_wr;
    logic               w_cpu_stall;

    // ---------------------------------------------------------------- state
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= CPU_OWN;
            r_wait_cnt  <= '0;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_wait_cnt  <= w_wait_nxt;
            r_burst_cnt <= w_burst_nxt;
        end
    end

    // ----------------------------------------------------------- next state
    // NOTE: every variable gets a default at the top of the block so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        w_burst_nxt = r_burst_cnt;
        case (r_state)
            CPU_OWN: begin
                if (w_dma_gnt || !bus.dma_req) begin
                    w_wait_nxt = '0;
                end else if (bus.cpu_req) begin
                    // Contended cycle: DMA loses to the CPU once more.
                    if (r_wait_cnt == WAIT_LAST) begin
                        w_state_nxt = FORCE;
                        w_wait_nxt  = '0;
                    end else begin
                        w_wait_nxt = r_wait_cnt + 1'b1;
                    end
                end
            end
            FORCE: begin
                w_wait_nxt = '0;
                // In FORCE a pending DMA request is always granted, so
                // dma_req alone tells whether an access happens this cycle.
                if (!bus.dma_req || (r_burst_cnt == BURST_LAST)) begin
                    w_state_nxt = CPU_OWN;
                    w_burst_nxt = '0;
                end else begin
                    w_burst_nxt = r_burst_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = CPU_OWN;
                w_burst_nxt = '0;
            end
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        w_cpu_gnt   = (r_state == CPU_OWN) && bus.cpu_req;
        w_dma_gnt   = (r_state == FORCE) ? bus.dma_req
                                         : (!bus.cpu_req && bus.dma_req);
        w_dma_rd    = w_dma_gnt && !bus.dma_we;
        // With no grant the CPU fields stay on the bus; rd/wr are both low.
        w_mem_addr  = w_dma_gnt ? bus.dma_addr  : bus.cpu_addr;
        w_mem_wdata = w_dma_gnt ? bus.dma_wdata : bus.cpu_wdata;
        w_mem_rd    = (w_cpu_gnt && !bus.cpu_we) || w_dma_rd;
        w_mem_wr    = (w_cpu_gnt &&  bus.cpu_we) || (w_dma_gnt && bus.dma_we);
        w_cpu_stall = (r_state == FORCE) && bus.cpu_req;
    end

    assign bus.dma_gnt   = w_dma_gnt;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;
    assign bus.mem_rd    = w_mem_rd;
    assign bus.mem_wr    = w_mem_wr;
    assign bus.cpu_stall = w_cpu_stall;
    assign bus.cpu_rdata = bus.mem_rdata;
    assign bus.in_burst  = (r_state == FORCE);

    // ------------------------------------------------------ DMA read return
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dma_rvalid <= 1'b0;
            r_dma_rdata  <= '0;
        end else begin
            r_dma_rvalid <= w_dma_rd;
            if (w_dma_rd) begin
                r_dma_rdata <= bus.mem_rdata;
            end
        end
    end

    assign bus.dma_rvalid = r_dma_rvalid;
    assign bus.dma_rdata  = r_dma_rdata;

endmodule
